// File: rtl/snn_tdm_lif_layer.sv
// snn_tdm_lif_layer: time-multiplexed LIF neuron layer; define SNN_LAYER_WINNER_EN for a running spike-count argmax
module snn_tdm_lif_layer #(
    parameter int NUM_NEURONS = 10,
    parameter int TIME_STEPS = 100,
    parameter int POT_WIDTH = 16,
    parameter int CUR_WIDTH = 16,
    parameter int THRESHOLD = 550,
    parameter int RESET_POT = 0,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRACTORY = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               cur_req,
    output logic [$clog2(NUM_NEURONS)-1:0]     cur_idx,
    input  logic                               cur_valid,
    input  logic signed [CUR_WIDTH-1:0]        cur_data,
    output logic                               spk_valid,
    output logic [$clog2(NUM_NEURONS)-1:0]     spk_idx,
    output logic                               spk,
    output logic                               step_done,
    output logic [$clog2(TIME_STEPS+1)-1:0]    time_step,
    output logic [NUM_NEURONS-1:0]             spike_vec,
    input  logic [$clog2(NUM_NEURONS)-1:0]     cnt_rd_idx,
    output logic [CNT_WIDTH-1:0]               cnt_rd_data,
    output logic [$clog2(NUM_NEURONS)-1:0]     winner_idx,
    output logic [CNT_WIDTH-1:0]               winner_cnt
);
    localparam int IW = $clog2(NUM_NEURONS);
    localparam int TW = $clog2(TIME_STEPS + 1);
    localparam int RW = $clog2(REFRACTORY + 2);
    localparam int SW = POT_WIDTH + 2;
    localparam logic signed [SW-1:0] POS_MAX = {3'b000, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] NEG_MIN = {3'b111, {(POT_WIDTH-1){1'b0}}};
    localparam logic signed [POT_WIDTH-1:0] RST_V = POT_WIDTH'(RESET_POT);
    localparam logic signed [POT_WIDTH-1:0] THR = POT_WIDTH'(THRESHOLD);
    localparam logic [RW-1:0] REFR_V = RW'(REFRACTORY);

    typedef enum logic [2:0] {IDLE, INIT, FETCH, STEP_END, DONE} state_t;

    state_t                      state_q;
    logic signed [POT_WIDTH-1:0] v_q [NUM_NEURONS];
    logic [RW-1:0]               refr_q [NUM_NEURONS];
    logic [CNT_WIDTH-1:0]        cnt_q [NUM_NEURONS];
    logic [IW-1:0]               idx_q;
    logic [NUM_NEURONS-1:0]      shadow_q;
    logic [NUM_NEURONS-1:0]      spike_vec_q;
    logic [TW-1:0]               time_step_q;
    logic                        spk_valid_q;
    logic                        spk_q;
    logic [IW-1:0]               spk_idx_q;

    logic                        xfer;
    logic                        refr_act;
    logic                        fire_d;
    logic                        last_n;
    logic                        last_t;
    logic signed [POT_WIDTH-1:0] v_cur;
    logic signed [POT_WIDTH-1:0] leak;
    logic signed [SW-1:0]        sum;
    logic signed [POT_WIDTH-1:0] s_d;
    logic [CNT_WIDTH-1:0]        cnt_d;

    // Headroom of two bits lets the leak/current sum be clamped instead of wrapping
    assign xfer     = state_q == FETCH && cur_valid;
    assign v_cur    = v_q[idx_q];
    assign leak     = v_cur >>> LEAK_SHIFT;
    assign sum      = SW'(v_cur) - SW'(leak) + SW'(cur_data);
    assign s_d      = sum > POS_MAX ? POS_MAX[POT_WIDTH-1:0] :
                      sum < NEG_MIN ? NEG_MIN[POT_WIDTH-1:0] : sum[POT_WIDTH-1:0];
    assign refr_act = refr_q[idx_q] != '0;
    assign fire_d   = !refr_act && s_d >= THR;
    assign cnt_d    = &cnt_q[idx_q] ? cnt_q[idx_q] : cnt_q[idx_q] + 1'b1;
    assign last_n   = idx_q == IW'(NUM_NEURONS - 1);
    assign last_t   = time_step_q == TW'(TIME_STEPS - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || state_q == INIT) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]    <= RST_V;
                refr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            shadow_q <= '0;
        end else if (xfer) begin
            v_q[idx_q]      <= refr_act || fire_d ? RST_V : s_d;
            refr_q[idx_q]   <= refr_act ? refr_q[idx_q] - 1'b1 : fire_d ? REFR_V : '0;
            cnt_q[idx_q]    <= fire_d ? cnt_d : cnt_q[idx_q];
            shadow_q[idx_q] <= fire_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            time_step_q <= '0;
            spike_vec_q <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            spk_q       <= 1'b0;
        end else begin
            spk_valid_q <= xfer;
            spk_idx_q   <= xfer ? idx_q : spk_idx_q;
            spk_q       <= xfer ? fire_d : spk_q;
            case (state_q)
                IDLE: state_q <= start ? INIT : IDLE;
                INIT: begin
                    idx_q       <= '0;
                    time_step_q <= '0;
                    state_q     <= FETCH;
                end
                FETCH: if (cur_valid) begin
                    idx_q   <= last_n ? idx_q : idx_q + 1'b1;
                    state_q <= last_n ? STEP_END : FETCH;
                end
                STEP_END: begin
                    spike_vec_q <= shadow_q;
                    time_step_q <= time_step_q + 1'b1;
                    idx_q       <= '0;
                    state_q     <= last_t ? DONE : FETCH;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign cur_req     = state_q == FETCH;
    assign step_done   = state_q == STEP_END;
    assign cur_idx     = idx_q;
    assign spk_valid   = spk_valid_q;
    assign spk_idx     = spk_idx_q;
    assign spk         = spk_q;
    assign time_step   = time_step_q;
    assign spike_vec   = spike_vec_q;
    assign cnt_rd_data = cnt_q[cnt_rd_idx];

`ifdef SNN_LAYER_WINNER_EN
    logic [IW-1:0]        win_idx_q;
    logic [CNT_WIDTH-1:0] win_cnt_q;

    // Neurons are visited in ascending order, so strict > plus the index tie-break keeps the lowest index
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == INIT) begin
            win_idx_q <= '0;
            win_cnt_q <= '0;
        end else if (xfer && fire_d) begin
            if (cnt_d > win_cnt_q) begin
                win_idx_q <= idx_q;
                win_cnt_q <= cnt_d;
            end else if (cnt_d == win_cnt_q && idx_q < win_idx_q) begin
                win_idx_q <= idx_q;
            end
        end
    end

    assign winner_idx = win_idx_q;
    assign winner_cnt = win_cnt_q;
`else
    assign winner_idx = '0;
    assign winner_cnt = '0;
`endif
endmodule
